seq_multiplier: RTL and testbench

- Sequential shift-and-add unsigned multiplier for the calculator datapath. It is the multiply-direction counterpart to the Divider's iterate-and-count engine.
- Accepts two Data_width operands on a GO pulse and iterates one multiplier bit per clock under a down-counting step counter.
- Presents a 2*Data_width product with a one-cycle DONE strobe.
- Sits beside the Divider and is selected by the calculator's operation decoder.

---
 rtl/seq_multiplier_pkg.sv | 14 +
 rtl/seq_multiplier_if.sv | 15 +
 rtl/seq_multiplier_step_counter.sv | 31 +++
 rtl/seq_multiplier.sv | 108 ++++++++++
 tb/tb_seq_multiplier.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared state encoding and counter direction constants for the calculator
// arithmetic engines (multiplier and divider).
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier: requester drives GO/A/B,
// the multiplier returns P/BUSY/DONE.
interface seq_multiplier_if #(
  parameter int Data_width = 4
);
  logic                    GO;
  logic [Data_width-1:0]   A;
  logic [Data_width-1:0]   B;
  logic [2*Data_width-1:0] P;
  logic                    BUSY;
  logic                    DONE;

  modport master (output GO, output A, output B, input P, input BUSY, input DONE);
  modport slave  (input GO, input A, input B, output P, output BUSY, output DONE);
endinterface

// File: rtl/seq_multiplier_step_counter.sv
// Loadable step counter with clock enable; counts in direction DIR
// (down for the multiplier).
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int   CNT_width = 3,
  parameter logic DIR       = DOWN
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD,
  input  logic [CNT_width-1:0] D,
  input  logic                 CE,
  output logic [CNT_width-1:0] Q
);

  logic [CNT_width-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (LD) begin
      r_cnt <= D;
    end else if (CE) begin
      r_cnt <= (DIR == UP) ? r_cnt + 1'b1 : r_cnt - 1'b1;
    end
  end

  assign Q = r_cnt;

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock, DONE strobe.
// MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int Data_width = 4,
  parameter int CNT_width  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  seq_multiplier_if.slave  bus
);

  state_t                  r_state;
  logic [2*Data_width-1:0] r_m;
  logic [Data_width-1:0]   r_r;
  logic [2*Data_width-1:0] r_acc;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_ld;
  logic                    w_ce;
  logic [CNT_width-1:0]    w_cnt;
  logic                    w_last;

  assign w_ld = (r_state == ST_IDLE) && bus.GO;
  assign w_ce = (r_state == ST_CALC);

  mult_step_counter #(
    .CNT_width (CNT_width),
    .DIR       (DOWN)
  ) u_step_counter (
    .CLK (CLK),
    .RST (RST),
    .LD  (w_ld),
    .D   (CNT_width'(Data_width)),
    .CE  (w_ce),
    .Q   (w_cnt)
  );

`ifdef MULT_EARLY_EXIT_EN
  // Remaining multiplier bits exhausted: further iterations would add nothing.
  logic [Data_width-1:0] w_r_next;
  assign w_r_next = r_r >> 1;
  assign w_last   = (w_cnt == CNT_width'(1)) || (w_r_next == '0);
`else
  assign w_last   = (w_cnt == CNT_width'(1));
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_r     <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.GO) begin
            r_m    <= {{Data_width{1'b0}}, bus.A};
            r_r    <= bus.B;
            r_acc  <= '0;
            r_busy <= 1'b1;
`ifdef MULT_EARLY_EXIT_EN
            if (bus.B == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_CALC;
            end
`else
            r_state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (r_r[0]) begin
            r_acc <= r_acc + r_m;
          end
          r_m <= r_m << 1;
          r_r <= r_r >> 1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P    = r_acc;
  assign bus.BUSY = r_busy;
  assign bus.DONE = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus queues expected product and
// CALC-cycle count, a negedge monitor checks each DONE strobe against them.
module tb_seq_multiplier;

  localparam int DW = 4;

  typedef struct {
    logic [2*DW-1:0] p;
    int              calc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  seq_multiplier_if #(.Data_width(DW)) bus();

  seq_multiplier #(.Data_width(DW), .CNT_width(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  exp_t            exp_q[$];
  int              errs    = 0;
  int              checks  = 0;
  int              n_done  = 0;
  int              calc_ct = 0;
  logic            prev_done = 1'b0;
  logic [2*DW-1:0] held_p  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected CALC-cycle count for multiplier b.
  function automatic int exp_calc(input logic [DW-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int n = 0;
    for (int i = 0; i < DW; i++) if (b[i]) n = i + 1;
    return n;
`else
    return DW;
`endif
  endfunction

  // Monitor
  always @(negedge CLK) begin
    if (RST) begin
      calc_ct   = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        chk("done_one_cycle", {31'd0, bus.DONE}, 32'd0);
        chk("idle_after_done", {31'd0, bus.BUSY}, 32'd0);
        chk("p_held", {24'd0, bus.P}, {24'd0, held_p});
      end
      if (bus.DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", {24'd0, bus.P}, {24'd0, e.p});
          chk("calc_cycles", calc_ct, e.calc);
          held_p = e.p;
        end
        n_done++;
        calc_ct = 0;
      end else if (bus.BUSY) begin
        calc_ct++;
      end
      prev_done = bus.DONE;
    end
  end

  task automatic wait_done();
    int target = n_done + 1;
    int budget = 40;
    while (n_done < target && budget > 0) begin
      @(posedge CLK); #2;
      budget--;
    end
    if (n_done < target) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2*DW-1:0] p, input bit chg);
    exp_t e;
    e.p = p; e.calc = exp_calc(b);
    bus.A = a; bus.B = b; bus.GO = 1'b1;
    exp_q.push_back(e);
    @(posedge CLK); #2;
    bus.GO = 1'b0;
    chk("busy_after_go", {31'd0, bus.BUSY}, 32'd1);
    if (chg) begin
      bus.A = '1; bus.B = '1;
    end
    wait_done();
  endtask

  initial begin
    exp_t e;
    bus.GO = 1'b0; bus.A = '0; bus.B = '0;
    #23;
    chk("rst_p", {24'd0, bus.P}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #2;

    do_op(4'hF, 4'hF, 8'hE1, 1'b0);

    // GO held high: the second operation starts only in the IDLE cycle after DONE.
    bus.A = 4'h6; bus.B = 4'h3; bus.GO = 1'b1;
    e.p = 8'h12; e.calc = exp_calc(4'h3); exp_q.push_back(e);
    wait_done();
    bus.A = 4'h2; bus.B = 4'h5;
    e.p = 8'h0A; e.calc = exp_calc(4'h5); exp_q.push_back(e);
    @(posedge CLK); #2;
    bus.GO = 1'b0;
    chk("busy_restart", {31'd0, bus.BUSY}, 32'd1);
    wait_done();

    do_op(4'h0, 4'h9, 8'h00, 1'b0);
    do_op(4'h9, 4'h0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of CALC, away from any clock edge.
    bus.A = 4'hD; bus.B = 4'hB; bus.GO = 1'b1;
    @(posedge CLK); #2;
    bus.GO = 1'b0;
    @(posedge CLK); #2;
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    chk("arst_p", {24'd0, bus.P}, 32'd0);
    chk("arst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("arst_done", {31'd0, bus.DONE}, 32'd0);
    exp_q.delete();
    #7;
    RST = 1'b0;
    @(posedge CLK); #2;
    do_op(4'h2, 4'h3, 8'h06, 1'b0);

    do_op(4'h5, 4'h7, 8'h23, 1'b1);

    do_op(4'h3, 4'h1, 8'h03, 1'b0);
    do_op(4'h3, 4'h0, 8'h00, 1'b0);
    do_op(4'h3, 4'h8, 8'h18, 1'b0);

    repeat (4) @(posedge CLK);
    #2;
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", n_done, 32'd10);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
